fc_hwacc_cfg_seq: RTL
=====================

// Module: fc_hwacc_cfg_seq
// PURPOSE
//  Job sequencer for the FC hardware accelerator config (periph) port. Buffers
//  queued register writes (addr/data) in a FIFO and issues them in order on the
//  accelerator's periph req/gnt bus. Each job ends with a trigger write (cmd_last_i).
//  After the trigger, waits for the accelerator event. Reports completion or
//  timeout to the FC.
// PARAMETERS
//  FIFO_DEPTH  4   command FIFO entries (power of 2, >=2)
//  ADDR_WIDTH  32  periph address width
//  TO_WIDTH    16  event-timeout counter width
// PORTS
//  clk_i         in   1           clock
//  rst_ni        in   1           reset, synchronous, active-low
//  cmd_valid_i   in   1           command valid
//  cmd_ready_o   out  1           command FIFO not full
//  cmd_addr_i    in   ADDR_WIDTH  target register address
//  cmd_data_i    in   32          write data
//  cmd_last_i    in   1           trigger write, ends the job
//  timeout_i     in   TO_WIDTH    event timeout in cycles; 0 = disabled
//  per_req_o     out  1           periph request
//  per_gnt_i     in   1           periph grant
//  per_add_o     out  ADDR_WIDTH  periph address
//  per_wen_o     out  1           0 = write (always 0)
//  per_be_o      out  4           byte enables (always 4'hF)
//  per_wdata_o   out  32          periph write data
//  per_r_valid_i in   1           periph response valid
//  evt_i         in   1           accelerator done event (1-cycle pulse)
//  busy_o        out  1           FSM not IDLE, or FIFO not empty
//  done_o        out  1           1-cycle pulse: job completed
//  err_o         out  1           1-cycle pulse: job timed out
//  job_cnt_o     out  16          completed-job counter, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (rst_ni=0 at clk edge)
//   - FIFO flushed. FSM returns to IDLE. Counters cleared.
//   - All outputs 0 except per_be_o=4'hF.
//   - cmd_ready_o=1 from the first cycle after reset deasserts.
//   - Reset mid-transaction drops per_req_o immediately; a late per_r_valid_i is ignored.
//  FIFO
//   - Push when cmd_valid_i & cmd_ready_o.
//   - cmd_ready_o = !full. It does not depend on a same-cycle pop.
//   - Pointers wrap modulo FIFO_DEPTH. An occupancy counter separates full from empty.
//  FSM
//   - IDLE: FIFO non-empty -> ISSUE, next cycle. Head entry is not popped yet.
//   - ISSUE: per_req_o=1; add/wdata driven from the FIFO head and held stable until gnt.
//       On per_gnt_i: pop head, latch its last flag -> WAIT_RSP.
//   - WAIT_RSP: per_req_o=0. On per_r_valid_i:
//       last=1 -> WAIT_EVT;
//       last=0 and FIFO non-empty -> ISSUE;
//       otherwise -> IDLE.
//   - WAIT_EVT: on evt pending -> done_o=1, job_cnt_o+1 -> IDLE.
//   - WAIT_EVT, no event, timeout_i!=0: on to_cnt==timeout_i-1 -> err_o=1, job not counted -> IDLE.
//   - Back-to-back write issue costs 2 cycles (ISSUE, WAIT_RSP) when gnt and r_valid come immediately.
//  Event handling
//   - evt_i is latched into evt_pend in any cycle from the trigger-write gnt cycle onward.
//     An event arriving in WAIT_RSP is not lost.
//   - evt_pend clears on leaving WAIT_EVT.
//   - evt_i is ignored in IDLE, in ISSUE and in WAIT_RSP of non-trigger writes.
//  Timeout counter
//   - to_cnt clears on WAIT_EVT entry and increments each WAIT_EVT cycle.
//   - Event and timeout in the same cycle: event wins (done_o=1, err_o=0).
//  Other rules
//   - Commands pushed during WAIT_EVT stay queued. They are not issued until the FSM leaves WAIT_EVT.
//   - A job with no trigger entry issues its writes and returns to IDLE without waiting.
// TESTING
//  1. Push 3 cmds (A0..A2; last on A2); gnt the cycle after req, r_valid the cycle after gnt; evt 5 cycles later
//     -> 3 writes in order with correct add/wdata, done_o pulse, job_cnt_o=1.
//  2. Push 5 cmds with FIFO_DEPTH=4 and gnt held low -> cmd_ready_o=0 after 4 pushes;
//     the 5th is accepted only after the first gnt; write order preserved.
//  3. evt_i asserted in the WAIT_RSP cycle of the trigger write -> evt latched, done_o pulse, no err_o.
//  4. timeout_i=10, no evt -> err_o pulses exactly 10 cycles after WAIT_EVT entry; job_cnt_o unchanged; FSM IDLE.
//  5. evt_i and timeout expiry in the same cycle -> done_o=1, err_o=0.
//  6. rst_ni low while in ISSUE with 2 entries queued -> next cycle per_req_o=0, busy_o=0, cmd_ready_o=1;
//     a stale per_r_valid_i has no effect.

Source files
------------

// File: rtl/fc_hwacc_cfg_seq.sv
// fc_hwacc_cfg_seq: job sequencer that queues accelerator config writes and issues them on the periph bus
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o        command push handshake (addr, data, last = trigger write)
//   timeout_i                      event timeout in cycles, 0 disables it
//   per_req_o/per_gnt_i ...        periph write bus towards the accelerator
//   evt_i                          accelerator done event
//   busy_o, done_o, err_o          status and per-job completion / timeout pulses
//   job_cnt_o                      completed-job counter
module fc_hwacc_cfg_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int TO_WIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]           cmd_data_i,
   input  logic                  cmd_last_i,
   input  logic [TO_WIDTH-1:0]   timeout_i,
   output logic                  per_req_o,
   input  logic                  per_gnt_i,
   output logic [ADDR_WIDTH-1:0] per_add_o,
   output logic                  per_wen_o,
   output logic [3:0]            per_be_o,
   output logic [31:0]           per_wdata_o,
   input  logic                  per_r_valid_i,
   input  logic                  evt_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [15:0]           job_cnt_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, WAIT_EVT} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
   logic [31:0]           mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_last;
   logic [PW-1:0]         wptr, rptr;
   logic [PW:0]           cnt;
   logic [TO_WIDTH-1:0]   to_cnt;
   logic full, empty, push, pop, issue, in_evt, last_q, evt_pend, evt_hit, evt_arm, to_hit;

   assign full        = cnt == (PW+1)'(FIFO_DEPTH);
   assign empty       = cnt == '0;
   // rst_ni gates ready so nothing is offered to the FC while reset is held
   assign cmd_ready_o = rst_ni & ~full;
   assign push        = cmd_valid_i & cmd_ready_o;
   assign issue       = state == ISSUE;
   assign in_evt      = state == WAIT_EVT;
   assign pop         = issue & per_gnt_i;
   assign evt_hit     = evt_pend | evt_i;
   assign to_hit      = (timeout_i != '0) & (to_cnt == timeout_i - TO_WIDTH'(1));
   // events count from the trigger-write grant onward, so a fast accelerator is not missed
   assign evt_arm     = (pop & mem_last[rptr]) | ((state == WAIT_RSP) & last_q) | in_evt;
   assign per_wen_o   = 1'b0;
   assign per_be_o    = 4'hF;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop) rptr <= rptr + PW'(1);
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_addr[wptr] <= cmd_addr_i;
         mem_data[wptr] <= cmd_data_i;
         mem_last[wptr] <= cmd_last_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = empty ? IDLE : ISSUE;
         ISSUE:    state_nxt = per_gnt_i ? WAIT_RSP : ISSUE;
         WAIT_RSP: state_nxt = !per_r_valid_i ? WAIT_RSP : last_q ? WAIT_EVT : !empty ? ISSUE : IDLE;
         WAIT_EVT: state_nxt = (evt_hit | to_hit) ? IDLE : WAIT_EVT;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      per_req_o   = issue;
      per_add_o   = issue ? mem_addr[rptr] : '0;
      per_wdata_o = issue ? mem_data[rptr] : '0;
      done_o      = in_evt & evt_hit;
      err_o       = in_evt & ~evt_hit & to_hit;
      busy_o      = (state != IDLE) | ~empty;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q    <= 1'b0;
         evt_pend  <= 1'b0;
         to_cnt    <= '0;
         job_cnt_o <= '0;
      end else begin
         if (pop) last_q <= mem_last[rptr];
         evt_pend <= (done_o | err_o) ? 1'b0 : evt_pend | (evt_i & evt_arm);
         to_cnt   <= in_evt ? to_cnt + TO_WIDTH'(1) : '0;
         if (done_o) job_cnt_o <= job_cnt_o + 16'd1;
      end
   end
endmodule
